// File: rtl/onchip_mem_pixel_reader.sv
// Avalon-MM read master for the on-chip pixel buffer: fetches a word block and
// streams each 32-bit word out as two RGB565 pixels, low half first.
module onchip_mem_pixel_reader #(
    parameter int ADDR_W     = 12,
    parameter int MEM_WORDS  = 3072,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [12:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_FIN} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [12:0]       cnt_q, remain_q, pop_left_q;
    logic              rej_q, inflight, half;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fifo_used;
    logic [AW+1:0]     occ;
    logic [13:0]       end_addr;
    logic [31:0]       head;
    logic              reject, issue, push, pop, accept;

    // Words buffered plus the read in flight bound how far issue may run ahead.
    assign occ      = {1'b0, fifo_used} + (AW+2)'(inflight);
    assign issue    = (state == S_READ) && (remain_q != 13'd0) && (occ < (AW+2)'(FIFO_DEPTH));
    assign end_addr = 14'(addr_q) + 14'(cnt_q);
    assign reject   = (cnt_q == 13'd0) || (cnt_q > 13'(MEM_WORDS)) || (end_addr > 14'(MEM_WORDS));

    assign head      = fifo_mem[rd_ptr];
    assign pix_valid = (fifo_used != '0);
    assign accept    = pix_valid & pix_ready;
    assign push      = inflight;
    assign pop       = accept & half;
    assign pix_data  = pix_valid ? (half ? head[31:16] : head[15:0]) : 16'h0000;
    assign pix_last  = pix_valid & half & (pop_left_q == 13'd1);

    assign busy           = (state == S_CHECK) || (state == S_READ) || (state == S_DRAIN);
    assign done           = (state == S_FIN);
    assign err            = (state == S_FIN) & rej_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CHECK;
            S_CHECK: state_nx = reject ? S_FIN : S_READ;
            S_READ:  if (issue && remain_q == 13'd1) state_nx = S_DRAIN;
            // Leave as soon as the final upper half is taken, not a cycle later.
            S_DRAIN: if (!inflight && (fifo_used == '0 || (fifo_used == (AW+1)'(1) && pop)))
                         state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            remain_q   <= '0;
            pop_left_q <= '0;
            rej_q      <= 1'b0;
            inflight   <= 1'b0;
            half       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_used  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_q     <= base_addr;
                cnt_q      <= word_count;
                remain_q   <= word_count;
                pop_left_q <= word_count;
            end
            if (state == S_CHECK) rej_q <= reject;
            if (issue) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 13'd1;
            end
            inflight <= issue;
            if (accept) half <= ~half;
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                pop_left_q <= pop_left_q - 13'd1;
            end
            if (push && !pop)      fifo_used <= fifo_used + 1'b1;
            else if (pop && !push) fifo_used <= fifo_used - 1'b1;
        end
    end

    // Storage needs no reset: pix_valid derives from fifo_used alone.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_readdata;
    end
endmodule

// File: tb/tb_onchip_mem_pixel_reader.sv
// Directed bench for onchip_mem_pixel_reader with a 1-cycle-latency memory model.
module tb_onchip_mem_pixel_reader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        busy, done, err;
    logic [11:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = '0;
    logic [15:0] pix_data;
    logic        pix_valid, pix_last;
    logic        pix_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int max_used = 0;
    logic [15:0] pix_q[$];
    logic        last_q[$];
    logic [11:0] adr_q[$];
    logic [31:0] mem [0:3071];

    onchip_mem_pixel_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int a);
        logic [15:0] lo;
        lo = 16'(a);
        if (a == 0) return 32'hBEEF_1234;
        return {lo ^ 16'hC3C3, lo + 16'h1000};
    endfunction

    function automatic logic [15:0] exp_pix(input int base, input int k);
        logic [31:0] w;
        w = word_of(base + k / 2);
        return (k % 2 == 1) ? w[31:16] : w[15:0];
    endfunction

    // Memory: data for an issued address appears the following cycle.
    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

    always @(negedge clk) begin
        if (reset_n) begin
            if (pix_valid && pix_ready) begin
                pix_q.push_back(pix_data);
                last_q.push_back(pix_last);
            end
            if (mem_chipselect) adr_q.push_back(mem_address);
            if (int'(dut.fifo_used) > max_used) max_used = int'(dut.fifo_used);
        end
    end

    task automatic clear_obs();
        pix_q.delete();
        last_q.delete();
        adr_q.delete();
        max_used = 0;
    endtask

    task automatic pulse_start(input int b, input int c);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'(b); word_count = 13'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output bit e);
        got = 0; e = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1; e = err; return; end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, err, pix_valid, pix_last, mem_chipselect, mem_address} !== 18'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0",
                {busy, done, err, pix_valid, pix_last, mem_chipselect, mem_address});
        end
        checks++;
        if ({mem_write, mem_byteenable, mem_clken} !== 6'b0_1111_1) begin
            errors++; $display("FAIL const_outputs got=%b want=011111", {mem_write, mem_byteenable, mem_clken});
        end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_single_word();
        clear_obs();
        pix_ready = 1'b1;
        pulse_start(0, 1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_chipselect !== 1'b0) begin
            errors++; $display("FAIL t1_check_cycle busy=%b cs=%b want busy=1 cs=0", busy, mem_chipselect);
        end
        @(negedge clk);
        checks++;
        if (mem_chipselect !== 1'b1 || mem_address !== 12'd0) begin
            errors++; $display("FAIL t1_issue cs=%b addr=%0d want cs=1 addr=0", mem_chipselect, mem_address);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++; $display("FAIL t1_no_early_pixel valid=%b want 0", pix_valid);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 16'h1234 || pix_last !== 1'b0) begin
            errors++; $display("FAIL t1_pix0 v=%b d=%h l=%b want v=1 d=1234 l=0", pix_valid, pix_data, pix_last);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 16'hBEEF || pix_last !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL t1_pix1 v=%b d=%h l=%b done=%b want v=1 d=beef l=1 done=0",
                pix_valid, pix_data, pix_last, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL t1_done done=%b err=%b busy=%b v=%b want 1 0 0 0", done, err, busy, pix_valid);
        end
    endtask

    task automatic test_top_boundary();
        bit got, e;
        int bad;
        clear_obs();
        pix_ready = 1'b1;
        pulse_start(3068, 4);
        wait_done(200, got, e);
        checks++;
        if (!got || e) begin errors++; $display("FAIL t2_done got=%0d err=%0d want 1 0", got, e); end
        bad = 0;
        if (adr_q.size() != 4) bad++;
        else for (int i = 0; i < 4; i++) if (adr_q[i] !== 12'(3068 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t2_addresses n=%0d bad=%0d want 4 in order 3068..3071", adr_q.size(), bad); end
        bad = 0;
        if (pix_q.size() != 8) bad++;
        else for (int k = 0; k < 8; k++)
            if (pix_q[k] !== exp_pix(3068, k) || last_q[k] !== (k == 7)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t2_pixels n=%0d bad=%0d want 8 exact", pix_q.size(), bad); end
    endtask

    task automatic test_reject();
        int bs[3] = '{3070, 3070, 0};
        int cs[3] = '{3, 0, 3073};
        for (int t = 0; t < 3; t++) begin
            clear_obs();
            pulse_start(bs[t], cs[t]);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL t3_case%0d_early done=%b busy=%b want 0 1", t, done, busy);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL t3_case%0d_done done=%b err=%b busy=%b want 1 1 0", t, done, err, busy);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (adr_q.size() != 0 || pix_q.size() != 0) begin
                errors++; $display("FAIL t3_case%0d_noreads reads=%0d pixels=%0d want 0 0", t, adr_q.size(), pix_q.size());
            end
        end
    endtask

    task automatic test_random_ready();
        bit got;
        int bad;
        clear_obs();
        got = 0;
        pulse_start(100, 64);
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk); #1 pix_ready = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            if (done) got = 1;
        end
        pix_ready = 1'b1;
        checks++;
        if (!got) begin errors++; $display("FAIL t4_done timeout"); end
        bad = 0;
        if (pix_q.size() != 128) bad++;
        else for (int k = 0; k < 128; k++)
            if (pix_q[k] !== exp_pix(100, k) || last_q[k] !== (k == 127)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t4_stream n=%0d bad=%0d want 128 exact", pix_q.size(), bad); end
        checks++;
        if (max_used > 4) begin errors++; $display("FAIL t4_fifo_bound max=%0d want <=4", max_used); end
    endtask

    task automatic test_backpressure();
        bit got, e;
        int bad, cs_late, unstable;
        logic [15:0] held;
        clear_obs();
        pix_ready = 1'b1;
        pulse_start(200, 32);
        repeat (6) @(negedge clk);
        @(posedge clk); #1 pix_ready = 1'b0;
        cs_late = 0; unstable = 0;
        @(negedge clk);
        held = pix_data;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid !== 1'b1 || pix_data !== held) unstable++;
            if (i >= 10 && mem_chipselect) cs_late++;
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL t5_hold unstable_cycles=%0d want 0", unstable); end
        checks++;
        if (cs_late != 0 || int'(dut.fifo_used) != 4) begin
            errors++; $display("FAIL t5_stall late_issues=%0d used=%0d want 0 4", cs_late, dut.fifo_used);
        end
        @(posedge clk); #1 pix_ready = 1'b1;
        wait_done(500, got, e);
        bad = 0;
        if (!got || pix_q.size() != 64) bad++;
        else for (int k = 0; k < 64; k++) if (pix_q[k] !== exp_pix(200, k)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t5_stream n=%0d bad=%0d want 64 exact", pix_q.size(), bad); end
    endtask

    task automatic test_reset_mid_job();
        bit got, e;
        int bad;
        clear_obs();
        pix_ready = 1'b1;
        pulse_start(0, 100);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, pix_valid, pix_last, mem_chipselect, mem_address, pix_data} !== 34'd0) begin
            errors++; $display("FAIL t6_reset_outputs got=%h want 0",
                {busy, done, err, pix_valid, pix_last, mem_chipselect, mem_address, pix_data});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_obs();
        pulse_start(500, 2);
        wait_done(200, got, e);
        bad = 0;
        if (!got || e || pix_q.size() != 4) bad++;
        else for (int k = 0; k < 4; k++)
            if (pix_q[k] !== exp_pix(500, k) || last_q[k] !== (k == 3)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t6_restart n=%0d got=%0d bad=%0d want 4 clean pixels", pix_q.size(), got, bad); end
    endtask

    initial begin
        for (int i = 0; i < 3072; i++) mem[i] = word_of(i);
        test_reset();
        test_single_word();
        test_top_boundary();
        test_reject();
        test_random_ready();
        test_backpressure();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
